// File: rtl/seg7_tick_counter.sv
// rtl/seg7_tick_counter.sv - prescaled single-digit counter with start/stop/clear/load and hex segment decode
module seg7_tick_counter #(
    parameter logic [23:0] TICK_COUNT   = 24'd10_000_000,
    parameter int          CNT_W        = 24,
    parameter int          PERIOD_SHIFT = 10,
    parameter logic [3:0]  DIGIT_MAX    = 4'd9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic [1:0] mode,
    input  logic [7:0] period_in,
    output logic [3:0] digit,
    output logic [6:0] segments,
    output logic       dp,
    output logic       tick,
    output logic       wrap,
    output logic       running
);

    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } state_t;

    localparam logic [1:0] MODE_UP     = 2'b00;
    localparam logic [1:0] MODE_DOWN   = 2'b01;
    localparam logic [1:0] MODE_PING   = 2'b10;
    localparam int         PW          = 8 + PERIOD_SHIFT;
    localparam logic [CNT_W-1:0] DEF_TERM = CNT_W'(TICK_COUNT - 24'd1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] pre_q, pre_d;
    logic [3:0]       digit_q, digit_d;
    logic             dir_q, dir_d;
    logic             dp_q, dp_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;

    logic [CNT_W-1:0] term;
    logic [PW-1:0]    period_full;
    logic             is_running;
    logic             hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_STOPPED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOPPED: if (start && !stop) state_d = ST_RUNNING;
            ST_RUNNING: if (stop)           state_d = ST_STOPPED;
            default:                        state_d = ST_STOPPED;
        endcase
    end

    always_comb begin
        is_running = (state_q == ST_RUNNING);
    end

    // Comparing with >= keeps a shrinking period from running pre all the way around.
    always_comb begin
        period_full = {period_in, {PERIOD_SHIFT{1'b0}}};
        if (period_in == 8'd0) begin
            term = DEF_TERM;
        end else begin
            term = CNT_W'(period_full) - CNT_W'(1);
        end
        hit = is_running && (pre_q >= term);
    end

    always_comb begin
        pre_d   = pre_q;
        digit_d = digit_q;
        dir_d   = dir_q;
        dp_d    = dp_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        if (clear) begin
            pre_d   = '0;
            digit_d = 4'd0;
            dir_d   = 1'b1;
            dp_d    = 1'b0;
        end else if (load) begin
            pre_d   = '0;
            digit_d = (load_val > DIGIT_MAX) ? DIGIT_MAX : load_val;
        end else begin
            if (is_running) begin
                pre_d = hit ? '0 : pre_q + CNT_W'(1);
            end
            if (hit) begin
                tick_d = 1'b1;
                dp_d   = ~dp_q;
                case (mode)
                    MODE_UP: begin
                        if (digit_q >= DIGIT_MAX) begin
                            digit_d = 4'd0;
                            wrap_d  = 1'b1;
                        end else begin
                            digit_d = digit_q + 4'd1;
                        end
                    end
                    MODE_DOWN: begin
                        if (digit_q == 4'd0 || digit_q > DIGIT_MAX) begin
                            digit_d = DIGIT_MAX;
                            wrap_d  = 1'b1;
                        end else begin
                            digit_d = digit_q - 4'd1;
                        end
                    end
                    MODE_PING: begin
                        if (digit_q > DIGIT_MAX) begin
                            digit_d = 4'd0;
                            dir_d   = 1'b1;
                            wrap_d  = 1'b1;
                        end else if (dir_q) begin
                            if (digit_q == DIGIT_MAX) begin
                                digit_d = DIGIT_MAX - 4'd1;
                                dir_d   = 1'b0;
                                wrap_d  = 1'b1;
                            end else begin
                                digit_d = digit_q + 4'd1;
                            end
                        end else begin
                            if (digit_q == 4'd0) begin
                                digit_d = 4'd1;
                                dir_d   = 1'b1;
                                wrap_d  = 1'b1;
                            end else begin
                                digit_d = digit_q - 4'd1;
                            end
                        end
                    end
                    default: digit_d = digit_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q   <= '0;
            digit_q <= 4'd0;
            dir_q   <= 1'b1;
            dp_q    <= 1'b0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            digit_q <= digit_d;
            dir_q   <= dir_d;
            dp_q    <= dp_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        running = is_running;
        digit   = digit_q;
        dp      = dp_q;
        tick    = tick_q;
        wrap    = wrap_q;
        case (digit_q)
            4'h0:    segments = 7'h3F;
            4'h1:    segments = 7'h06;
            4'h2:    segments = 7'h5B;
            4'h3:    segments = 7'h4F;
            4'h4:    segments = 7'h66;
            4'h5:    segments = 7'h6D;
            4'h6:    segments = 7'h7D;
            4'h7:    segments = 7'h07;
            4'h8:    segments = 7'h7F;
            4'h9:    segments = 7'h6F;
            4'hA:    segments = 7'h77;
            4'hB:    segments = 7'h7C;
            4'hC:    segments = 7'h39;
            4'hD:    segments = 7'h5E;
            4'hE:    segments = 7'h79;
            default: segments = 7'h71;
        endcase
    end

endmodule
